// File: rtl/knight_motion.sv
// knight_motion: per-frame walk/jump/fall motion of a sprite; optional air jump with KNIGHT_DOUBLE_JUMP_EN
module knight_motion #(
  parameter int X_START  = 320,
  parameter int Y_GROUND = 400,
  parameter int X_MIN    = 24,
  parameter int X_MAX    = 615,
  parameter int Y_MIN    = 32,
  parameter int STEP_X   = 2,
  parameter int JUMP_V   = 10,
  parameter int GRAVITY  = 1,
  parameter int VMAX     = 8,
  parameter int SIZE_X   = 50,
  parameter int SIZE_Y   = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [15:0] keycode,
  output logic [9:0]  BallX,
  output logic [9:0]  BallY,
  output logic [9:0]  Ball_sizeX,
  output logic [9:0]  Ball_sizeY,
  output logic [3:0]  BallStatus,
  output logic        facing
);
  typedef enum logic [1:0] {IDLE, WALK, JUMP, FALL} state_t;
  localparam logic [9:0]         XS    = 10'(X_START);
  localparam logic [9:0]         YG    = 10'(Y_GROUND);
  localparam logic [9:0]         XMIN  = 10'(X_MIN);
  localparam logic [9:0]         XLO   = 10'(X_MIN + STEP_X);
  localparam logic [9:0]         STEP  = 10'(STEP_X);
  localparam logic [10:0]        XMAX  = 11'(X_MAX);
  localparam logic [9:0]         YMIN  = 10'(Y_MIN);
  localparam logic signed [11:0] YMIN_S = 12'(Y_MIN);
  localparam logic signed [11:0] YG_S  = 12'(Y_GROUND);
  localparam logic signed [7:0]  VJ    = 8'(-JUMP_V);
  localparam logic signed [7:0]  GRAV  = 8'(GRAVITY);
  localparam logic signed [7:0]  VMX   = 8'(VMAX);
  state_t             r_st, w_st_nxt;
  logic [9:0]         r_x, r_y, w_x_nxt, w_y_nxt;
  logic signed [7:0]  r_vy, w_vy_nxt, w_vsum, w_vadd;
  logic signed [11:0] w_ysum;
  logic [10:0]        w_xp;
  logic [9:0]         w_x_right, w_x_left;
  logic               r_face, w_face_nxt, r_fc_d, r_jump_d;
  logic               w_tick, w_left, w_right, w_jump, w_hl, w_hr, w_h, w_req, w_air, w_ground;
  assign w_tick    = frame_clk & ~r_fc_d;
  assign w_left    = keycode[15:8] == 8'h04 || keycode[7:0] == 8'h04;
  assign w_right   = keycode[15:8] == 8'h07 || keycode[7:0] == 8'h07;
  assign w_jump    = keycode[15:8] == 8'h1A || keycode[7:0] == 8'h1A ||
                     keycode[15:8] == 8'h2C || keycode[7:0] == 8'h2C;
  assign w_hl      = w_left & ~w_right;
  assign w_hr      = w_right & ~w_left;
  assign w_h       = w_hl | w_hr;
  assign w_req     = w_jump & ~r_jump_d;
  assign w_ground  = r_st == IDLE || r_st == WALK;
  assign w_xp      = {1'b0, r_x} + {1'b0, STEP};
  assign w_x_right = w_xp > XMAX ? XMAX[9:0] : w_xp[9:0];
  assign w_x_left  = r_x < XLO ? XMIN : r_x - STEP;
  assign w_ysum    = $signed({2'b00, r_y}) + 12'(r_vy);
  assign w_vsum    = r_vy + GRAV;
  assign w_vadd    = w_vsum > VMX ? VMX : w_vsum;
`ifdef KNIGHT_DOUBLE_JUMP_EN
  logic r_credit;
  assign w_air = w_req & r_credit & ~w_ground;
  // air-jump credit: spent by an air jump, refilled whenever the sprite is on the ground
  always_ff @(posedge Clk) begin
    if (Reset) r_credit <= 1'b1;
    else if (w_tick) r_credit <= w_air ? 1'b0 : (w_st_nxt == IDLE || w_st_nxt == WALK) ? 1'b1 : r_credit;
  end
`else
  assign w_air = 1'b0;
`endif
  // motion state register, advanced only on a frame tick; reset wins over tick
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fc_d   <= 1'b0;
      r_jump_d <= 1'b0;
      r_st     <= IDLE;
      r_x      <= XS;
      r_y      <= YG;
      r_vy     <= '0;
      r_face   <= 1'b0;
    end else begin
      r_fc_d <= frame_clk;
      if (w_tick) begin
        r_jump_d <= w_jump;
        r_st     <= w_st_nxt;
        r_x      <= w_x_nxt;
        r_y      <= w_y_nxt;
        r_vy     <= w_vy_nxt;
        r_face   <= w_face_nxt;
      end
    end
  end
  // next position, velocity, state and facing for the coming tick
  always_comb begin
    w_st_nxt   = r_st;
    w_y_nxt    = r_y;
    w_vy_nxt   = r_vy;
    w_x_nxt    = w_hr ? w_x_right : w_hl ? w_x_left : r_x;
    w_face_nxt = w_hr ? 1'b0 : w_hl ? 1'b1 : r_face;
    if (w_ground) begin
      if (w_req) begin
        w_st_nxt = JUMP;
        w_vy_nxt = VJ;
      end else begin
        w_st_nxt = w_h ? WALK : IDLE;
        w_y_nxt  = YG;
        w_vy_nxt = '0;
      end
    end else if (w_air) begin
      w_st_nxt = JUMP;
      w_vy_nxt = VJ;
    end else if (r_st == JUMP && w_ysum < YMIN_S) begin
      w_st_nxt = FALL;
      w_y_nxt  = YMIN;
      w_vy_nxt = '0;
    end else if (r_st == FALL && w_ysum >= YG_S) begin
      w_st_nxt = w_h ? WALK : IDLE;
      w_y_nxt  = YG;
      w_vy_nxt = '0;
    end else begin
      w_y_nxt  = w_ysum[9:0];
      w_vy_nxt = w_vadd;
      w_st_nxt = (r_st == JUMP && !w_vadd[7]) ? FALL : r_st;
    end
  end
  assign BallX      = r_x;
  assign BallY      = r_y;
  assign Ball_sizeX = 10'(SIZE_X);
  assign Ball_sizeY = 10'(SIZE_Y);
  assign BallStatus = {2'b00, r_st};
  assign facing     = r_face;
endmodule

// File: tb/tb_knight_motion.sv
// tb_knight_motion: randomized and directed checks of knight_motion against a frame-level physics model
module tb_knight_motion;
  logic        Clk = 0, Reset = 1, frame_clk = 0;
  logic [15:0] keycode = 0;
  logic [9:0]  BallX, BallY, Ball_sizeX, Ball_sizeY;
  logic [3:0]  BallStatus;
  logic        facing;
  int total = 0, bad = 0;
  int mx, my, mvy, mst, mface, mprev, mcredit;
`ifdef KNIGHT_DOUBLE_JUMP_EN
  localparam bit DJ = 1;
`else
  localparam bit DJ = 0;
`endif

  knight_motion dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .BallX(BallX), .BallY(BallY), .Ball_sizeX(Ball_sizeX), .Ball_sizeY(Ball_sizeY),
    .BallStatus(BallStatus), .facing(facing)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 320; my = 400; mvy = 0; mst = 0; mface = 0; mprev = 0; mcredit = 1;
  endtask

  task automatic model_step(input logic [15:0] k);
    bit l, r, j, h, req;
    int yn, vn;
    l = k[15:8] == 8'h04 || k[7:0] == 8'h04;
    r = k[15:8] == 8'h07 || k[7:0] == 8'h07;
    j = k[15:8] == 8'h1A || k[7:0] == 8'h1A || k[15:8] == 8'h2C || k[7:0] == 8'h2C;
    h = l != r;
    if (r && !l) begin mx = (mx + 2 > 615) ? 615 : mx + 2; mface = 0; end
    if (l && !r) begin mx = (mx - 2 < 24) ? 24 : mx - 2; mface = 1; end
    req = j && !mprev;
    mprev = j;
    if (mst < 2) begin
      if (req) begin mst = 2; mvy = -10; end
      else begin mst = h ? 1 : 0; my = 400; mvy = 0; end
    end else if (DJ && req && mcredit == 1) begin
      mst = 2; mvy = -10; mcredit = 0;
    end else begin
      yn = my + mvy;
      vn = (mvy + 1 > 8) ? 8 : mvy + 1;
      if (mst == 2 && yn < 32) begin my = 32; mvy = 0; mst = 3; end
      else if (mst == 3 && yn >= 400) begin my = 400; mvy = 0; mst = h ? 1 : 0; mcredit = 1; end
      else begin my = yn; mvy = vn; if (mst == 2 && vn >= 0) mst = 3; end
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".x"}, BallX, mx);
    chk({tag, ".y"}, BallY, my);
    chk({tag, ".st"}, BallStatus, mst);
    chk({tag, ".face"}, facing, mface);
  endtask

  task automatic frame(input logic [15:0] k);
    @(negedge Clk);
    keycode = k;
    frame_clk = 1;
    model_step(k);
    @(negedge Clk);
    chk_model("tick");
    @(negedge Clk);
    frame_clk = 0;
    keycode = 16'($urandom);
    repeat (2) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1;
    frame_clk = 1;
    keycode = 16'h0007;
    @(negedge Clk);
    model_reset();
    chk_model("rst");
    Reset = 0;
    frame_clk = 0;
    keycode = 0;
  endtask

  initial begin
    logic [15:0] pool [9];
    pool = '{16'h0000, 16'h0004, 16'h0007, 16'h002C, 16'h1A00, 16'h0407, 16'h072C, 16'h2C04, 16'h0000};
    model_reset();
    repeat (3) @(negedge Clk);
    do_reset();
    chk("size_x", Ball_sizeX, 50);
    chk("size_y", Ball_sizeY, 64);
    repeat (5) frame(16'h0000);
    chk("idle_x", BallX, 320);
    chk("idle_y", BallY, 400);
    chk("idle_st", BallStatus, 0);
    chk("idle_face", facing, 0);
    repeat (10) frame(16'h0007);
    chk("walk_x", BallX, 340);
    chk("walk_st", BallStatus, 1);
    repeat (200) frame(16'h0400);
    chk("sat_x", BallX, 24);
    chk("sat_face", facing, 1);
    frame(16'h0000);
    frame(16'h002C);
    chk("jump_st", BallStatus, 2);
    chk("jump_y", BallY, 400);
    repeat (9) frame(16'h0000);
    chk("rise9_st", BallStatus, 2);
    frame(16'h0000);
    chk("peak_y", BallY, 345);
    chk("peak_st", BallStatus, 3);
    repeat (11) frame(16'h0000);
    chk("fall11_st", BallStatus, 3);
    frame(16'h0000);
    chk("land_y", BallY, 400);
    chk("land_st", BallStatus, 0);
    repeat (40) frame(16'h2C00);
    chk("hold_st", BallStatus, 0);
    frame(16'h0000);
    frame(16'h001A);
    chk("repress_st", BallStatus, 2);
    repeat (12) frame(16'h0000);
    frame(16'h002C);
    chk("air_st", BallStatus, DJ ? 2 : 3);
    frame(16'h0000);
    frame(16'h002C);
    chk("air3_st", BallStatus, DJ ? 2 : 3);
    repeat (40) frame(16'h0000);
    chk("land2_st", BallStatus, 0);
    frame(16'h0407);
    chk("both_x", BallX, 24);
    chk("both_st", BallStatus, 0);
    frame(16'h002C);
    repeat (13) frame(16'h0000);
    chk("midfall_st", BallStatus, 3);
    do_reset();
    chk("rst_fall_y", BallY, 400);
    chk("rst_fall_st", BallStatus, 0);
    for (int i = 0; i < 600; i++) begin
      logic [15:0] k;
      k = ($urandom_range(0, 9) == 0) ? 16'($urandom) : pool[$urandom_range(0, 8)];
      frame(k);
      if ($urandom_range(0, 199) == 0) do_reset();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/knight_motion.md
KNIGHT_MOTION -- requirements
Module: knight_motion

Interface
REQ-001 SHALL have parameter X_START, default 320, meaning reset X centre (pixels).
REQ-002 SHALL have parameter Y_GROUND, default 400, meaning floor Y centre.
REQ-003 SHALL have parameters X_MIN 24 / X_MAX 615 / Y_MIN 32, meaning position clamps.
REQ-004 SHALL have parameters STEP_X 2, JUMP_V 10, GRAVITY 1, VMAX 8, meaning per-frame motion constants.
REQ-005 SHALL have parameters SIZE_X 50, SIZE_Y 64, meaning sprite extent.
REQ-006 Clk  in  1  system clock; only clock, all state on rising edge.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 frame_clk  in  1  vertical-sync strobe, asynchronous-rate level signal.
REQ-009 keycode  in  16  two USB HID key codes [15:8],[7:0]; 0x00 = none.
REQ-010 BallX, BallY  out  10 each  sprite centre.
REQ-011 Ball_sizeX, Ball_sizeY  out  10 each  constant SIZE_X, SIZE_Y.
REQ-012 BallStatus  out  4  0 idle, 1 walk, 2 jump, 3 fall; 4-15 never driven.
REQ-013 facing  out  1  0 right, 1 left.

Function
REQ-014 SHALL register frame_clk once and form tick = frame_clk & ~frame_clk_d; all motion updates occur only on a tick cycle; outputs reflect the update one Clk after tick.
REQ-015 SHALL decode from either byte: 0x04 left, 0x07 right, 0x1A or 0x2C jump; left and right both present = no horizontal input.
REQ-016 Jump request SHALL be edge-qualified: jump present at this tick and absent at previous tick.
REQ-017 Horizontal: each tick X += STEP_X (right) or -= STEP_X (left), in every state, saturating at X_MIN/X_MAX; facing updates to last pressed direction, holds otherwise.
REQ-018 Vertical velocity vy SHALL be signed 8-bit; per tick Y_next = Y + vy, then vy_next = min(vy + GRAVITY, VMAX).
REQ-019 IDLE/WALK: jump request -> JUMP with vy = -JUMP_V (Y unchanged that tick); else horizontal input -> WALK, none -> IDLE; Y held at Y_GROUND.
REQ-020 JUMP: apply REQ-018; when vy_next >= 0 -> FALL.
REQ-021 JUMP with Y_next < Y_MIN: Y = Y_MIN, vy = 0, -> FALL.
REQ-022 FALL: apply REQ-018; if Y_next >= Y_GROUND: Y = Y_GROUND, vy = 0, -> WALK if horizontal input else IDLE.
REQ-023 Jump request in JUMP/FALL SHALL be ignored (unless REQ-028).
REQ-024 Ball_sizeX/Ball_sizeY SHALL be constant regardless of state.

Reset
REQ-025 Reset SHALL set BallX = X_START, BallY = Y_GROUND, vy = 0, BallStatus = 0, facing = 0, frame_clk_d = 0, jump history = 0, air-jump credit = 1.
REQ-026 Reset SHALL dominate tick in the same cycle; reset mid-air returns directly to ground idle.
REQ-027 No tick SHALL be generated in the cycle Reset is high.

Configuration
REQ-028 With KNIGHT_DOUBLE_JUMP_EN defined: one jump request in JUMP or FALL SHALL set vy = -JUMP_V, state JUMP, consume air-jump credit; credit restored on landing. Without it: REQ-023 applies, no credit register exists.

Verification
REQ-029 Reset, no keys, 5 ticks -> BallX 320, BallY 400, BallStatus 0, facing 0.
REQ-030 Hold 0x07 for 10 ticks -> BallX 340, BallStatus 1; hold 0x04 to 200 ticks -> BallX saturates 24, facing 1.
REQ-031 Press 0x2C one tick then release -> tick 1 BallStatus 2 BallY 400; next 10 ticks BallY reaches 345, BallStatus 3 after the 10th; lands BallY 400, BallStatus 0 twelve ticks later.
REQ-032 Hold 0x2C continuously from ground -> exactly one jump; second jump only after release and re-press post-landing.
REQ-033 keycode 0x0407 -> BallX unchanged, BallStatus 0; Reset asserted mid-FALL -> next cycle BallY 400, BallStatus 0.
REQ-034 With KNIGHT_DOUBLE_JUMP_EN, re-press jump in FALL -> BallStatus 2, vy -10; third press ignored until landing.
